instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the instruction address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the instruction word width.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, SHALL set the watchdog limit in cycles; it has effect only with FETCH_TIMEOUT_EN.
REQ-004 CLK_in  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 RST_n_in  in  1  SHALL be the reset, asynchronous and active-low.
REQ-006 Start_en  in  1  SHALL be run enable; 0 = CPU stopped, shared with the program counter.
REQ-007 PC_in  in  ADDR_W  SHALL be the current PC from the program counter output.
REQ-008 Halt_out  out  1  SHALL drive the program counter Halt_en; 1 = hold PC.
REQ-009 Mem_req_out  out  1  SHALL be the instruction-memory request strobe.
REQ-010 Mem_addr_out  out  ADDR_W  SHALL be the latched fetch address.
REQ-011 Mem_ack_in  in  1  SHALL be memory acknowledge; Mem_data_in is valid in the same cycle.
REQ-012 Mem_data_in  in  DATA_W  SHALL be the returned instruction word.
REQ-013 Instr_out  out  DATA_W  SHALL be the instruction presented to decode.
REQ-014 Instr_valid_out  out  1  SHALL mark Instr_out valid.
REQ-015 Decode_ready_in  in  1  SHALL be decode accept; transfer occurs when valid and ready are both 1.
REQ-016 Flush_in  in  1  SHALL discard the in-flight or held instruction, e.g. on a taken branch.
REQ-017 Fault_out  out  1  SHALL flag a misaligned PC or a fetch timeout; sticky.

Function
REQ-018 The FSM SHALL have four states: IDLE, REQ, HOLD and FAULT.
REQ-019 In IDLE with Start_en=1, the block SHALL latch PC_in into Mem_addr_out and enter REQ on the next edge.
REQ-020 In REQ, Mem_req_out SHALL be 1 and Mem_addr_out SHALL stay stable until Mem_ack_in=1.
REQ-021 On REQ with Mem_ack_in=1, the block SHALL register Mem_data_in into Instr_out, set Instr_valid_out=1 on the next edge and enter HOLD; minimum fetch latency is 1 cycle after the request.
REQ-022 In HOLD, Instr_out and Instr_valid_out SHALL stay stable until Decode_ready_in=1.
REQ-023 On HOLD with Decode_ready_in=1, the block SHALL latch PC_in, enter REQ and clear Instr_valid_out on the next edge.
REQ-024 Halt_out SHALL be 0 only in HOLD with Decode_ready_in=1 and Flush_in=0, so the PC advances exactly once per consumed instruction; Halt_out SHALL be 1 in all other running cases.
REQ-025 If PC_in[1:0]!=0 when latched, the block SHALL enter FAULT instead of REQ, set Fault_out=1, hold Mem_req_out=0 and hold Halt_out=1.
REQ-026 FAULT SHALL be left only by reset or by Start_en=0.
REQ-027 On Flush_in=1 in REQ, the block SHALL keep the request until ack, discard that data (no valid), then re-latch PC_in and re-enter REQ.
REQ-028 On Flush_in=1 together with Mem_ack_in=1, the data SHALL be discarded.
REQ-029 On Flush_in=1 in HOLD, the block SHALL clear Instr_valid_out, ignore Decode_ready_in and re-fetch from PC_in next.
REQ-030 Start_en=0 in any state SHALL synchronously force IDLE, clear valid, request and fault, and drive Halt_out=0; a pending memory ack SHALL be ignored.

Reset
REQ-031 While RST_n_in=0, the block SHALL be in IDLE with Instr_out=0, Instr_valid_out=0, Mem_req_out=0, Mem_addr_out=0, Halt_out=0, Fault_out=0 and the watchdog counter at 0.
REQ-032 Reset asserted mid-fetch SHALL abandon the transaction immediately; after release, fetch SHALL restart from PC_in.

Configuration
REQ-033 With FETCH_TIMEOUT_EN defined, a counter SHALL increment each REQ cycle without ack; on reaching TIMEOUT_CYCLES the block SHALL enter FAULT with Fault_out=1; the counter SHALL clear on entry to REQ.
REQ-034 Without FETCH_TIMEOUT_EN, REQ SHALL wait indefinitely, no counter logic SHALL exist, and TIMEOUT_CYCLES SHALL be ignored.

Structure
REQ-035 Shared package cpu_fetch_pkg SHALL hold the FSM state enum, ADDR_W/DATA_W defaults and the NOP instruction constant (32'h0000_0000).
REQ-036 The watchdog SHALL be a sub-module fetch_timeout_counter, instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-037 Reset, Start_en=1, PC_in=0x0, memory acks after 2 cycles with 0x2008_0005 -> Mem_req_out high for 3 cycles, Instr_out=0x2008_0005 with valid, Halt_out=1 until ready.
REQ-038 Decode_ready_in held at 1, PC stepping by 4, ack latency 0 -> one instruction every 2 cycles, Halt_out pulses low once per transfer.
REQ-039 PC_in=0x0000_0006 at latch -> FAULT, Fault_out=1, no request issued; Start_en=0 then 1 -> fault clears.
REQ-040 Flush_in=1 during REQ, ack 1 cycle later with 0xDEAD_BEEF -> no valid for that word, new request to the current PC_in.
REQ-041 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> Fault_out=1 after 4 REQ cycles; without the macro, still in REQ after 100 cycles.
REQ-042 RST_n_in low for 1 cycle mid-REQ -> all outputs 0 asynchronously; after release, fetch restarts from PC_in.

Source files
------------

// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: fetch FSM states, default widths and the NOP encoding shared by the fetch unit.
package cpu_fetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} fetch_state_t;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam logic [31:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/fetch_timeout_counter.sv
// fetch_timeout_counter: watchdog counting unacknowledged request cycles; o_expired fires on the LIMIT-th one.
module fetch_timeout_counter #(
    parameter int LIMIT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expired
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] r_count;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_count <= '0;
        else if (i_clear) r_count <= '0;
        else if (i_inc) r_count <= r_count + 1'b1;
    assign o_expired = i_inc && (r_count == W'(LIMIT - 1));
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetch between PC, instruction memory and decode.
// Define FETCH_TIMEOUT_EN to add a request watchdog that faults after TIMEOUT_CYCLES unacked cycles.
module instr_fetch_unit import cpu_fetch_pkg::*; #(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              CLK_in,
    input  logic              RST_n_in,
    input  logic              Start_en,
    input  logic [ADDR_W-1:0] PC_in,
    output logic              Halt_out,
    output logic              Mem_req_out,
    output logic [ADDR_W-1:0] Mem_addr_out,
    input  logic              Mem_ack_in,
    input  logic [DATA_W-1:0] Mem_data_in,
    output logic [DATA_W-1:0] Instr_out,
    output logic              Instr_valid_out,
    input  logic              Decode_ready_in,
    input  logic              Flush_in,
    output logic              Fault_out
);
    fetch_state_t      r_state, w_next_state;
    logic [ADDR_W-1:0] r_addr, w_next_addr;
    logic [DATA_W-1:0] r_instr, w_next_instr;
    logic              r_valid, w_next_valid;
    logic              r_flush_pend, w_next_flush_pend;
    logic              w_latch, w_expired;
`ifdef FETCH_TIMEOUT_EN
    fetch_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .i_clk     (CLK_in),
        .i_rst_n   (RST_n_in),
        .i_clear   (w_latch),
        .i_inc     (Start_en && r_state == REQ && !Mem_ack_in),
        .o_expired (w_expired)
    );
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign w_expired = 1'b0;
`endif
    always_ff @(posedge CLK_in or negedge RST_n_in)
        if (!RST_n_in) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_instr      <= DATA_W'(NOP);
            r_valid      <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_addr       <= w_next_addr;
            r_instr      <= w_next_instr;
            r_valid      <= w_next_valid;
            r_flush_pend <= w_next_flush_pend;
        end
    always_comb begin
        w_next_state      = r_state;
        w_next_addr       = r_addr;
        w_next_instr      = r_instr;
        w_next_valid      = r_valid;
        w_next_flush_pend = r_flush_pend;
        w_latch           = 1'b0;
        if (!Start_en) begin
            w_next_state      = IDLE;
            w_next_valid      = 1'b0;
            w_next_flush_pend = 1'b0;
        end else begin
            case (r_state)
                IDLE: w_latch = 1'b1;
                REQ:
                    if (Mem_ack_in) begin
                        // a flushed request still completes on the bus, but its word is dropped
                        if (Flush_in || r_flush_pend) begin
                            w_latch           = 1'b1;
                            w_next_flush_pend = 1'b0;
                        end else begin
                            w_next_instr = Mem_data_in;
                            w_next_valid = 1'b1;
                            w_next_state = HOLD;
                        end
                    end else if (w_expired) w_next_state = FAULT;
                    else if (Flush_in) w_next_flush_pend = 1'b1;
                HOLD:
                    if (Flush_in || Decode_ready_in) begin
                        w_latch      = 1'b1;
                        w_next_valid = 1'b0;
                    end
                default: ;
            endcase
            if (w_latch) begin
                w_next_addr  = PC_in;
                w_next_state = (PC_in[1:0] != 2'b00) ? FAULT : REQ;
            end
        end
    end
    assign Halt_out        = RST_n_in && Start_en && !(r_state == HOLD && Decode_ready_in && !Flush_in);
    assign Mem_req_out     = (r_state == REQ);
    assign Fault_out       = (r_state == FAULT);
    assign Mem_addr_out    = r_addr;
    assign Instr_out       = r_instr;
    assign Instr_valid_out = r_valid;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed self-checking bench for instr_fetch_unit (watchdog case follows FETCH_TIMEOUT_EN).
module tb_instr_fetch_unit;
    logic        CLK_in = 1'b0;
    logic        RST_n_in, Start_en, Mem_ack_in, Decode_ready_in, Flush_in;
    logic [31:0] PC_in, Mem_data_in;
    logic        Halt_out, Mem_req_out, Instr_valid_out, Fault_out;
    logic [31:0] Mem_addr_out, Instr_out;
    int          checks = 0;
    int          errors = 0;

    instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .CLK_in          (CLK_in),
        .RST_n_in        (RST_n_in),
        .Start_en        (Start_en),
        .PC_in           (PC_in),
        .Halt_out        (Halt_out),
        .Mem_req_out     (Mem_req_out),
        .Mem_addr_out    (Mem_addr_out),
        .Mem_ack_in      (Mem_ack_in),
        .Mem_data_in     (Mem_data_in),
        .Instr_out       (Instr_out),
        .Instr_valid_out (Instr_valid_out),
        .Decode_ready_in (Decode_ready_in),
        .Flush_in        (Flush_in),
        .Fault_out       (Fault_out)
    );

    always #5 CLK_in = ~CLK_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK_in);
        #1;
    endtask

    initial begin
        RST_n_in = 1'b0; Start_en = 1'b1; PC_in = 32'h0; Mem_ack_in = 1'b0;
        Mem_data_in = 32'h0; Decode_ready_in = 1'b0; Flush_in = 1'b0;
        #3;
        chk("rst_req", Mem_req_out, 0);
        chk("rst_addr", Mem_addr_out, 0);
        chk("rst_instr", Instr_out, 0);
        chk("rst_valid", Instr_valid_out, 0);
        chk("rst_halt", Halt_out, 0);
        chk("rst_fault", Fault_out, 0);
        step(); step();
        RST_n_in = 1'b1;
        #1;
        chk("idle_halt", Halt_out, 1);
        chk("idle_req", Mem_req_out, 0);
        // first fetch: ack arrives on the third request cycle
        step();
        chk("f0_req1", Mem_req_out, 1);
        chk("f0_addr", Mem_addr_out, 32'h0);
        chk("f0_halt", Halt_out, 1);
        step();
        chk("f0_req2", Mem_req_out, 1);
        step();
        chk("f0_req3", Mem_req_out, 1);
        Mem_ack_in = 1'b1; Mem_data_in = 32'h2008_0005;
        step();
        Mem_ack_in = 1'b0; Mem_data_in = 32'h0;
        #1;
        chk("f0_req_off", Mem_req_out, 0);
        chk("f0_valid", Instr_valid_out, 1);
        chk("f0_instr", Instr_out, 32'h2008_0005);
        chk("f0_halt_hold", Halt_out, 1);
        step();
        chk("f0_valid_stable", Instr_valid_out, 1);
        chk("f0_instr_stable", Instr_out, 32'h2008_0005);
        Decode_ready_in = 1'b1; PC_in = 32'h4;
        #1;
        chk("f0_halt_xfer", Halt_out, 0);
        step();
        chk("f1_valid_clr", Instr_valid_out, 0);
        chk("f1_req", Mem_req_out, 1);
        chk("f1_addr", Mem_addr_out, 32'h4);
        chk("f1_halt", Halt_out, 1);
        // back-to-back stream, zero ack latency, decode always ready
        for (int i = 0; i < 3; i++) begin
            Mem_ack_in = 1'b1; Mem_data_in = 32'hA000_0000 | (32'h4 + 32'(4 * i));
            #1;
            chk("bb_req", Mem_req_out, 1);
            chk("bb_addr", Mem_addr_out, 32'h4 + 32'(4 * i));
            chk("bb_halt_req", Halt_out, 1);
            step();
            chk("bb_valid", Instr_valid_out, 1);
            chk("bb_instr", Instr_out, 32'hA000_0004 + 32'(4 * i));
            chk("bb_halt_pulse", Halt_out, 0);
            PC_in = 32'h8 + 32'(4 * i);
            step();
        end
        Mem_ack_in = 1'b0; Decode_ready_in = 1'b0;
        // flush during request: word is dropped, next request goes to the new PC
        Flush_in = 1'b1; PC_in = 32'h100;
        #1;
        chk("fl_req_addr", Mem_addr_out, 32'h10);
        step();
        Flush_in = 1'b0;
        chk("fl_req_kept", Mem_req_out, 1);
        chk("fl_addr_kept", Mem_addr_out, 32'h10);
        Mem_ack_in = 1'b1; Mem_data_in = 32'hDEAD_BEEF;
        step();
        Mem_ack_in = 1'b0;
        chk("fl_no_valid", Instr_valid_out, 0);
        chk("fl_new_req", Mem_req_out, 1);
        chk("fl_new_addr", Mem_addr_out, 32'h100);
        // flush while holding: valid drops, ready ignored, refetch from PC_in
        Mem_ack_in = 1'b1; Mem_data_in = 32'h11;
        step();
        Mem_ack_in = 1'b0;
        chk("flh_valid", Instr_valid_out, 1);
        Flush_in = 1'b1; Decode_ready_in = 1'b1; PC_in = 32'h200;
        #1;
        chk("flh_halt", Halt_out, 1);
        step();
        Flush_in = 1'b0; Decode_ready_in = 1'b0;
        chk("flh_valid_clr", Instr_valid_out, 0);
        chk("flh_addr", Mem_addr_out, 32'h200);
        // misaligned PC at latch
        Mem_ack_in = 1'b1; Mem_data_in = 32'h22;
        step();
        Mem_ack_in = 1'b0; Decode_ready_in = 1'b1; PC_in = 32'h6;
        step();
        Decode_ready_in = 1'b0;
        chk("mis_fault", Fault_out, 1);
        chk("mis_req", Mem_req_out, 0);
        chk("mis_halt", Halt_out, 1);
        step();
        chk("mis_sticky", Fault_out, 1);
        chk("mis_no_req", Mem_req_out, 0);
        Start_en = 1'b0;
        #1;
        chk("stop_halt", Halt_out, 0);
        step();
        chk("stop_fault_clr", Fault_out, 0);
        Start_en = 1'b1; PC_in = 32'h8;
        step();
        chk("restart_req", Mem_req_out, 1);
        chk("restart_addr", Mem_addr_out, 32'h8);
        // stop with an ack pending: ack is ignored
        Start_en = 1'b0; Mem_ack_in = 1'b1; Mem_data_in = 32'h33;
        step();
        Mem_ack_in = 1'b0;
        chk("stop_ack_valid", Instr_valid_out, 0);
        chk("stop_ack_req", Mem_req_out, 0);
        Start_en = 1'b1; PC_in = 32'hC;
        step();
        chk("run_addr", Mem_addr_out, 32'hC);
`ifdef FETCH_TIMEOUT_EN
        repeat (3) step();
        chk("wd_not_yet", Fault_out, 0);
        step();
        chk("wd_fault", Fault_out, 1);
        chk("wd_req_off", Mem_req_out, 0);
        Start_en = 1'b0;
        step();
        Start_en = 1'b1;
        step();
`else
        repeat (100) step();
        chk("nowd_req", Mem_req_out, 1);
        chk("nowd_fault", Fault_out, 0);
`endif
        chk("pre_rst_addr", Mem_addr_out, 32'hC);
        // asynchronous reset in the middle of a request
        PC_in = 32'h40;
        RST_n_in = 1'b0;
        #1;
        chk("arst_req", Mem_req_out, 0);
        chk("arst_addr", Mem_addr_out, 0);
        chk("arst_halt", Halt_out, 0);
        chk("arst_fault", Fault_out, 0);
        chk("arst_valid", Instr_valid_out, 0);
        step();
        RST_n_in = 1'b1;
        step();
        chk("post_rst_req", Mem_req_out, 1);
        chk("post_rst_addr", Mem_addr_out, 32'h40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
